// File: rtl/control_unit_if.sv
// control_unit_if: strobe/status bundle between control_unit and Datapath2.
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        PCout, Zlowout, MDRout, BAout, Cout, InportOut;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
    logic        Gra, Grb, Grc, Rout, IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
    logic [3:0]  t_state;

    modport master (
        input  ir, con_ff, stop,
        output PCout, Zlowout, MDRout, BAout, Cout, InportOut,
               PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
               Gra, Grb, Grc, Rout, IncPC, Read, Write, alu_op, run, illegal, t_state
    );

    modport slave (
        output ir, con_ff, stop,
        input  PCout, Zlowout, MDRout, BAout, Cout, InportOut,
               PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
               Gra, Grb, Grc, Rout, IncPC, Read, Write, alu_op, run, illegal, t_state
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Datapath2 RISC datapath.
// Fetches in T0-T2, decodes ir[31:27] in T3 and drives execute strobes through T7.
module control_unit #(
    parameter logic [4:0] ALU_ADD = 5'd0,
    parameter logic [4:0] ALU_SUB = 5'd1,
    parameter logic [4:0] ALU_AND = 5'd2,
    parameter logic [4:0] ALU_OR  = 5'd3
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        RESET = 4'd8, HALT = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] op, alu_sel;
    logic       is_ld, is_ldi, is_st, is_alu, is_imm, is_brx, is_jr, is_in, is_out, is_nop, is_halt;
    logic       is_mem, is_bad, last, ir_unused;

    assign op        = bus.ir[31:27];
    assign ir_unused = ^bus.ir[26:0];
    assign is_ld     = op == 5'b00000;
    assign is_ldi    = op == 5'b00001;
    assign is_st     = op == 5'b00010;
    assign is_alu    = op >= 5'b00011 && op <= 5'b00110;
    assign is_imm    = op >= 5'b01100 && op <= 5'b01110;
    assign is_brx    = op == 5'b10010;
    assign is_jr     = op == 5'b10100;
    assign is_in     = op == 5'b10110;
    assign is_out    = op == 5'b10111;
    assign is_nop    = op == 5'b11010;
    assign is_halt   = op == 5'b11011;
    assign is_mem    = is_ldi | is_ld | is_st;
    assign is_bad    = !(is_mem | is_alu | is_imm | is_brx | is_jr | is_in | is_out | is_nop | is_halt);
    assign alu_sel   = (op == 5'b00100) ? ALU_SUB :
                       (op == 5'b00101 || op == 5'b01101) ? ALU_AND :
                       (op == 5'b00110 || op == 5'b01110) ? ALU_OR : ALU_ADD;

    always_ff @(posedge clk) begin
        state_q <= !clr ? RESET : state_d;
    end

    // stop only matters on the edge that retires an instruction
    always_comb begin
        last = (state_q == T3 && (is_jr | is_in | is_out | is_nop | is_bad))
            || (state_q == T5 && (is_alu | is_imm | is_ldi))
            || (state_q == T6 && is_brx)
            || state_q == T7;
        state_d = state_q;
        if (last)
            state_d = bus.stop ? HALT : T0;
        else
            case (state_q)
                RESET:   state_d = T0;
                T0:      state_d = T1;
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = is_halt ? HALT : T4;
                T4:      state_d = T5;
                T5:      state_d = T6;
                T6:      state_d = T7;
                default: state_d = state_q;
            endcase
    end

    always_comb begin
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.MDRout    = 1'b0;
        bus.BAout     = 1'b0;
        bus.Cout      = 1'b0;
        bus.InportOut = 1'b0;
        bus.PCin      = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.Rin       = 1'b0;
        bus.CONin     = 1'b0;
        bus.OutportIn = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rout      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.illegal   = 1'b0;
        bus.run       = state_q != RESET && state_q != HALT;
        bus.t_state   = state_q;
        case (state_q)
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                bus.Grb       = is_alu | is_imm | is_mem;
                bus.Yin       = is_alu | is_imm | is_mem;
                bus.BAout     = is_mem;
                bus.Rout      = is_alu | is_imm | is_brx | is_jr | is_out;
                bus.Gra       = is_brx | is_jr | is_in | is_out;
                bus.CONin     = is_brx;
                bus.PCin      = is_jr;
                bus.InportOut = is_in;
                bus.Rin       = is_in;
                bus.OutportIn = is_out;
                bus.illegal   = is_bad;
            end
            T4: begin
                bus.Grc    = is_alu;
                bus.Rout   = is_alu;
                bus.Cout   = is_imm | is_mem;
                bus.Zin    = is_alu | is_imm | is_mem;
                bus.alu_op = alu_sel;
                bus.PCout  = is_brx;
                bus.Yin    = is_brx;
            end
            T5: begin
                bus.Zlowout = is_alu | is_imm | is_mem;
                bus.Gra     = is_alu | is_imm | is_ldi;
                bus.Rin     = is_alu | is_imm | is_ldi;
                bus.MARin   = is_ld | is_st;
                bus.Cout    = is_brx;
                bus.Zin     = is_brx;
            end
            T6: begin
                bus.Read    = is_ld;
                bus.MDRin   = is_ld | is_st;
                bus.Gra     = is_st;
                bus.Rout    = is_st;
                bus.Zlowout = is_brx;
                bus.PCin    = is_brx & bus.con_ff;
            end
            T7: begin
                bus.MDRout = is_ld;
                bus.Gra    = is_ld;
                bus.Rin    = is_ld;
                bus.Write  = is_st;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle checks of state, strobes, alu_op and run.
module tb_control_unit;
    localparam logic [22:0] ILL = 23'd1 << 22, PCOUT = 23'd1 << 21, ZLOWOUT = 23'd1 << 20,
        MDROUT = 23'd1 << 19, BAOUT = 23'd1 << 18, COUT = 23'd1 << 17, INPORTOUT = 23'd1 << 16,
        PCIN = 23'd1 << 15, MARIN = 23'd1 << 14, MDRIN = 23'd1 << 13, IRIN = 23'd1 << 12,
        YIN = 23'd1 << 11, ZIN = 23'd1 << 10, RIN = 23'd1 << 9, CONIN = 23'd1 << 8,
        OUTPORTIN = 23'd1 << 7, GRA = 23'd1 << 6, GRB = 23'd1 << 5, GRC = 23'd1 << 4,
        ROUT = 23'd1 << 3, INCPC = 23'd1 << 2, READ = 23'd1 << 1, WRITE = 23'd1;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3;
    localparam logic [3:0] S_RESET = 4'd8, S_HALT = 4'd9;

    logic clk = 1'b0;
    logic clr;
    int checks = 0;
    int errors = 0;
    logic [22:0] strobes;

    control_unit_if bus ();
    control_unit dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    assign strobes = {bus.illegal, bus.PCout, bus.Zlowout, bus.MDRout, bus.BAout, bus.Cout, bus.InportOut,
                      bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.Rin, bus.CONin,
                      bus.OutportIn, bus.Gra, bus.Grb, bus.Grc, bus.Rout, bus.IncPC, bus.Read, bus.Write};

    task automatic step_chk(input string tag, input logic [3:0] ts, input logic [22:0] st,
                            input logic [4:0] op = 5'd0, input logic run_e = 1'b1);
        checks++;
        assert (bus.t_state === ts) else begin
            errors++;
            $error("FAIL %s t_state got %0d want %0d", tag, bus.t_state, ts);
        end
        checks++;
        assert (strobes === st) else begin
            errors++;
            $error("FAIL %s strobes got %06h want %06h", tag, strobes, st);
        end
        checks++;
        assert (bus.alu_op === op) else begin
            errors++;
            $error("FAIL %s alu_op got %0d want %0d", tag, bus.alu_op, op);
        end
        checks++;
        assert (bus.run === run_e) else begin
            errors++;
            $error("FAIL %s run got %b want %b", tag, bus.run, run_e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] instr);
        bus.ir = instr;
        step_chk({tag, ".T0"}, 4'd0, PCOUT | MARIN | INCPC | ZIN);
        step_chk({tag, ".T1"}, 4'd1, ZLOWOUT | PCIN | READ | MDRIN);
        step_chk({tag, ".T2"}, 4'd2, MDROUT | IRIN);
    endtask

    initial begin
        clr = 1'b0;
        bus.ir = 32'h0;
        bus.con_ff = 1'b0;
        bus.stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        step_chk("reset", S_RESET, 23'd0, ADD, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        fetch("ori", 32'h71180025);
        step_chk("ori.T3", 4'd3, GRB | ROUT | YIN);
        step_chk("ori.T4", 4'd4, COUT | ZIN, OR_);
        step_chk("ori.T5", 4'd5, ZLOWOUT | GRA | RIN);

        fetch("ld", 32'h00800010);
        step_chk("ld.T3", 4'd3, GRB | BAOUT | YIN);
        step_chk("ld.T4", 4'd4, COUT | ZIN);
        step_chk("ld.T5", 4'd5, ZLOWOUT | MARIN);
        step_chk("ld.T6", 4'd6, READ | MDRIN);
        step_chk("ld.T7", 4'd7, MDROUT | GRA | RIN);

        fetch("sub", 32'h20000000);
        step_chk("sub.T3", 4'd3, GRB | ROUT | YIN);
        step_chk("sub.T4", 4'd4, GRC | ROUT | ZIN, SUB);
        step_chk("sub.T5", 4'd5, ZLOWOUT | GRA | RIN);

        fetch("andi", 32'h68000000);
        step_chk("andi.T3", 4'd3, GRB | ROUT | YIN);
        step_chk("andi.T4", 4'd4, COUT | ZIN, AND_);
        step_chk("andi.T5", 4'd5, ZLOWOUT | GRA | RIN);

        fetch("ldi", 32'h08000000);
        step_chk("ldi.T3", 4'd3, GRB | BAOUT | YIN);
        step_chk("ldi.T4", 4'd4, COUT | ZIN);
        step_chk("ldi.T5", 4'd5, ZLOWOUT | GRA | RIN);

        fetch("st", 32'h10000000);
        step_chk("st.T3", 4'd3, GRB | BAOUT | YIN);
        step_chk("st.T4", 4'd4, COUT | ZIN);
        step_chk("st.T5", 4'd5, ZLOWOUT | MARIN);
        step_chk("st.T6", 4'd6, GRA | ROUT | MDRIN);
        step_chk("st.T7", 4'd7, WRITE);

        for (int c = 0; c < 2; c++) begin
            bus.con_ff = c[0];
            fetch("brx", 32'h90000000);
            step_chk("brx.T3", 4'd3, GRA | ROUT | CONIN);
            step_chk("brx.T4", 4'd4, PCOUT | YIN);
            step_chk("brx.T5", 4'd5, COUT | ZIN);
            step_chk("brx.T6", 4'd6, c[0] ? (ZLOWOUT | PCIN) : ZLOWOUT);
        end
        bus.con_ff = 1'b0;

        fetch("jr", 32'hA0000000);
        step_chk("jr.T3", 4'd3, GRA | ROUT | PCIN);
        fetch("in", 32'hB0000000);
        step_chk("in.T3", 4'd3, INPORTOUT | GRA | RIN);
        fetch("out", 32'hB8000000);
        step_chk("out.T3", 4'd3, GRA | ROUT | OUTPORTIN);
        fetch("nop", 32'hD0000000);
        step_chk("nop.T3", 4'd3, 23'd0);
        fetch("bad", 32'hF8000000);
        step_chk("bad.T3", 4'd3, ILL);

        fetch("add", 32'h18000000);
        step_chk("add.T3", 4'd3, GRB | ROUT | YIN);
        bus.stop = 1'b1;
        step_chk("add.T4", 4'd4, GRC | ROUT | ZIN, ADD);
        step_chk("add.T5", 4'd5, ZLOWOUT | GRA | RIN);
        for (int i = 0; i < 20; i++) step_chk("halt", S_HALT, 23'd0, ADD, 1'b0);

        clr = 1'b0;
        @(posedge clk);
        #1;
        step_chk("reset2", S_RESET, 23'd0, ADD, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;

        fetch("st2", 32'h10000000);
        step_chk("st2.T3", 4'd3, GRB | BAOUT | YIN);
        step_chk("st2.T4", 4'd4, COUT | ZIN);
        step_chk("st2.T5", 4'd5, ZLOWOUT | MARIN);
        clr = 1'b0;
        step_chk("st2.T6", 4'd6, GRA | ROUT | MDRIN);
        step_chk("st2.abort", S_RESET, 23'd0, ADD, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        fetch("hlt", 32'hD8000000);
        step_chk("hlt.T3", 4'd3, 23'd0);
        step_chk("hlt.H0", S_HALT, 23'd0, ADD, 1'b0);
        step_chk("hlt.H1", S_HALT, 23'd0, ADD, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
